// File: rtl/vx_writeback_arb_pkg.sv
// Shared definitions for the writeback arbiter.
//   - Unit identifiers (ALU=0, LSU=1, CSR=2, FPU=3, GPU=4).
//   - Default lane count, warp-id width and register-index width.
//   - Number of arbitration slots. It depends on EXT_F_COMMIT_EN:
//     5 slots when the FPU commit port is present, 4 slots otherwise.
//   - unit_slot(): maps a unit to its arbiter slot.
package vx_writeback_arb_pkg;

    localparam int NUM_THREADS_DEF = 4;
    localparam int NW_BITS_DEF     = 2;
    localparam int NR_BITS_DEF     = 5;

    typedef enum logic [2:0] {
        UNIT_ALU = 3'd0,
        UNIT_LSU = 3'd1,
        UNIT_CSR = 3'd2,
        UNIT_FPU = 3'd3,
        UNIT_GPU = 3'd4
    } unit_e;

`ifdef EXT_F_COMMIT_EN
    localparam int unsigned NUM_REQ = 5;
`else
    localparam int unsigned NUM_REQ = 4;
`endif

    // The GPU always takes the last slot. As a result, the cyclic order
    // ALU, LSU, CSR, [FPU,] GPU is the same whether or not the FPU is built.
    // The FPU slot is only meaningful when EXT_F_COMMIT_EN is defined.
    function automatic int unsigned unit_slot(unit_e u);
        case (u)
            UNIT_ALU: return 0;
            UNIT_LSU: return 1;
            UNIT_CSR: return 2;
            UNIT_FPU: return 3;
            default:  return NUM_REQ - 1;
        endcase
    endfunction

endpackage

// File: rtl/vx_writeback_arb_rr_arbiter.sv
// Round-robin arbiter.
// Search order: the search starts at the slot after the most recently
// granted one. After reset, slot 0 has first priority.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   requests[N]   : request vector
//   enable        : a grant is only issued (and the pointer moved) when set
//   grant_onehot  : one-hot grant, all zero when nothing is granted
//   grant_index   : index of the winning slot (valid when grant_onehot != 0)
module vx_writeback_arb_rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     requests,
    input  logic             enable,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_index
);

    logic [IDX_W-1:0] last_q;
    logic             found;

    always_comb begin
        int unsigned cand;
        grant_onehot = '0;
        grant_index  = '0;
        found        = 1'b0;
        cand         = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_q) + k) % N;
            if (!found && requests[cand[IDX_W-1:0]]) begin
                found       = 1'b1;
                grant_index = cand[IDX_W-1:0];
            end
        end
        if (found && enable)
            grant_onehot[grant_index] = 1'b1;
    end

    // The pointer resets to the last slot so that slot 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset)
            last_q <= IDX_W'(N - 1);
        else if (found && enable)
            last_q <= grant_index;
    end

endmodule

// File: rtl/vx_writeback_arb.sv
// Writeback arbiter: merges commits from the ALU, LSU, CSR, FPU and GPU into
// one registered writeback stream to the GPR file.
//   - Commits with U_wb=0 are accepted immediately and produce no writeback.
//   - Commits with U_wb=1 are arbitrated round-robin.
//   - The winner is loaded into a single output register when that stage is
//     free (!wb_valid || wb_ready).
// Configuration macro EXT_F_COMMIT_EN:
//   - defined   : the FPU commit port takes part in arbitration.
//   - undefined : fpu_ready is tied 0, fpu_* inputs are ignored, and a
//                 simulation assertion fires if fpu_valid is ever raised.
// Ports:
//   clk, reset (synchronous, active-high)
//   <U>_valid/_wid/_tmask/_PC/_rd/_wb/_data in, <U>_ready out,
//     for U in {alu, lsu, csr, fpu, gpu}
//   wb_valid/_wid/_tmask/_PC/_rd/_data out, wb_ready in
module vx_writeback_arb
    import vx_writeback_arb_pkg::*;
#(
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int NW_BITS     = NW_BITS_DEF,
    parameter int NR_BITS     = NR_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     alu_valid,
    input  logic [NW_BITS-1:0]       alu_wid,
    input  logic [NUM_THREADS-1:0]   alu_tmask,
    input  logic [31:0]              alu_PC,
    input  logic [NR_BITS-1:0]       alu_rd,
    input  logic                     alu_wb,
    input  logic [NUM_THREADS*32-1:0] alu_data,
    output logic                     alu_ready,

    input  logic                     lsu_valid,
    input  logic [NW_BITS-1:0]       lsu_wid,
    input  logic [NUM_THREADS-1:0]   lsu_tmask,
    input  logic [31:0]              lsu_PC,
    input  logic [NR_BITS-1:0]       lsu_rd,
    input  logic                     lsu_wb,
    input  logic [NUM_THREADS*32-1:0] lsu_data,
    output logic                     lsu_ready,

    input  logic                     csr_valid,
    input  logic [NW_BITS-1:0]       csr_wid,
    input  logic [NUM_THREADS-1:0]   csr_tmask,
    input  logic [31:0]              csr_PC,
    input  logic [NR_BITS-1:0]       csr_rd,
    input  logic                     csr_wb,
    input  logic [NUM_THREADS*32-1:0] csr_data,
    output logic                     csr_ready,

    input  logic                     fpu_valid,
    input  logic [NW_BITS-1:0]       fpu_wid,
    input  logic [NUM_THREADS-1:0]   fpu_tmask,
    input  logic [31:0]              fpu_PC,
    input  logic [NR_BITS-1:0]       fpu_rd,
    input  logic                     fpu_wb,
    input  logic [NUM_THREADS*32-1:0] fpu_data,
    output logic                     fpu_ready,

    input  logic                     gpu_valid,
    input  logic [NW_BITS-1:0]       gpu_wid,
    input  logic [NUM_THREADS-1:0]   gpu_tmask,
    input  logic [31:0]              gpu_PC,
    input  logic [NR_BITS-1:0]       gpu_rd,
    input  logic                     gpu_wb,
    input  logic [NUM_THREADS*32-1:0] gpu_data,
    output logic                     gpu_ready,

    output logic                     wb_valid,
    output logic [NW_BITS-1:0]       wb_wid,
    output logic [NUM_THREADS-1:0]   wb_tmask,
    output logic [31:0]              wb_PC,
    output logic [NR_BITS-1:0]       wb_rd,
    output logic [NUM_THREADS*32-1:0] wb_data,
    input  logic                     wb_ready
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned S_ALU = unit_slot(UNIT_ALU);
    localparam int unsigned S_LSU = unit_slot(UNIT_LSU);
    localparam int unsigned S_CSR = unit_slot(UNIT_CSR);
    localparam int unsigned S_GPU = unit_slot(UNIT_GPU);
`ifdef EXT_F_COMMIT_EN
    localparam int unsigned S_FPU = unit_slot(UNIT_FPU);
`endif

    logic [NUM_REQ-1:0]        req_claim;
    logic [NUM_REQ-1:0]        grant_onehot;
    logic [IDX_W-1:0]          grant_index;
    logic [NW_BITS-1:0]        src_wid   [NUM_REQ];
    logic [NUM_THREADS-1:0]    src_tmask [NUM_REQ];
    logic [31:0]               src_pc    [NUM_REQ];
    logic [NR_BITS-1:0]        src_rd    [NUM_REQ];
    logic [NUM_THREADS*32-1:0] src_data  [NUM_REQ];
    logic                      stage_free;
    logic                      grant_any;

    // Pack the unit ports into slot-indexed arrays for the arbiter and mux.
    always_comb begin
        req_claim[S_ALU] = alu_valid && alu_wb;
        src_wid[S_ALU]   = alu_wid;
        src_tmask[S_ALU] = alu_tmask;
        src_pc[S_ALU]    = alu_PC;
        src_rd[S_ALU]    = alu_rd;
        src_data[S_ALU]  = alu_data;

        req_claim[S_LSU] = lsu_valid && lsu_wb;
        src_wid[S_LSU]   = lsu_wid;
        src_tmask[S_LSU] = lsu_tmask;
        src_pc[S_LSU]    = lsu_PC;
        src_rd[S_LSU]    = lsu_rd;
        src_data[S_LSU]  = lsu_data;

        req_claim[S_CSR] = csr_valid && csr_wb;
        src_wid[S_CSR]   = csr_wid;
        src_tmask[S_CSR] = csr_tmask;
        src_pc[S_CSR]    = csr_PC;
        src_rd[S_CSR]    = csr_rd;
        src_data[S_CSR]  = csr_data;
`ifdef EXT_F_COMMIT_EN
        req_claim[S_FPU] = fpu_valid && fpu_wb;
        src_wid[S_FPU]   = fpu_wid;
        src_tmask[S_FPU] = fpu_tmask;
        src_pc[S_FPU]    = fpu_PC;
        src_rd[S_FPU]    = fpu_rd;
        src_data[S_FPU]  = fpu_data;
`endif
        req_claim[S_GPU] = gpu_valid && gpu_wb;
        src_wid[S_GPU]   = gpu_wid;
        src_tmask[S_GPU] = gpu_tmask;
        src_pc[S_GPU]    = gpu_PC;
        src_rd[S_GPU]    = gpu_rd;
        src_data[S_GPU]  = gpu_data;
    end

    assign stage_free = !wb_valid || wb_ready;

    vx_writeback_arb_rr_arbiter #(
        .N (NUM_REQ)
    ) rr_arbiter (
        .clk          (clk),
        .reset        (reset),
        .requests     (req_claim),
        .enable       (stage_free && !reset),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index)
    );

    assign grant_any = |grant_onehot;

    // A commit without a register write never waits. A commit with a
    // register write is accepted only when it holds the grant, which already
    // implies a free stage and no reset.
    assign alu_ready = !reset && (!alu_wb || grant_onehot[S_ALU]);
    assign lsu_ready = !reset && (!lsu_wb || grant_onehot[S_LSU]);
    assign csr_ready = !reset && (!csr_wb || grant_onehot[S_CSR]);
    assign gpu_ready = !reset && (!gpu_wb || grant_onehot[S_GPU]);

`ifdef EXT_F_COMMIT_EN
    assign fpu_ready = !reset && (!fpu_wb || grant_onehot[S_FPU]);
`else
    logic unused_fpu;
    assign unused_fpu = ^{fpu_valid, fpu_wid, fpu_tmask, fpu_PC, fpu_rd, fpu_wb, fpu_data};
    assign fpu_ready  = 1'b0;

    fpu_port_absent_a: assert property (@(posedge clk) disable iff (reset) !fpu_valid);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            wb_valid <= 1'b0;
        else if (stage_free)
            wb_valid <= grant_any;
    end

    // The payload is not reset: it is don't-care while wb_valid is low.
    always_ff @(posedge clk) begin
        if (stage_free && grant_any) begin
            wb_wid   <= src_wid[grant_index];
            wb_tmask <= src_tmask[grant_index];
            wb_PC    <= src_pc[grant_index];
            wb_rd    <= src_rd[grant_index];
            wb_data  <= src_data[grant_index];
        end
    end

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Testbench for vx_writeback_arb.
// Expected behaviour comes from a unit-level model:
//   - last-granted unit id, round-robin over unit ids 0..4;
//   - a single output register.
// Directed scenarios add literal expectations on top of the model.
// Honours EXT_F_COMMIT_EN for the FPU.
module tb_vx_writeback_arb;

    localparam int NT = 4;
    localparam int NW = 2;
    localparam int NR = 5;
    localparam int DW = NT * 32;
`ifdef EXT_F_COMMIT_EN
    localparam bit HAS_FPU = 1'b1;
    localparam int NREQ    = 5;
    int order[5] = '{0, 1, 2, 3, 4};
`else
    localparam bit HAS_FPU = 1'b0;
    localparam int NREQ    = 4;
    int order[5] = '{0, 1, 2, 4, 0};
`endif

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic wb_ready = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]    v = '0;
    logic [4:0]    w = '0;
    logic [4:0]    rdy;
    logic [NW-1:0] wid [5];
    logic [NT-1:0] tm  [5];
    logic [31:0]   pc  [5];
    logic [NR-1:0] rd  [5];
    logic [DW-1:0] dat [5];
    int            cnt [5];
    bit            acc [5];

    logic          wb_valid;
    logic [NW-1:0] wb_wid;
    logic [NT-1:0] wb_tmask;
    logic [31:0]   wb_PC;
    logic [NR-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    vx_writeback_arb #(
        .NUM_THREADS (NT),
        .NW_BITS     (NW),
        .NR_BITS     (NR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (v[0]), .alu_wid (wid[0]), .alu_tmask (tm[0]), .alu_PC (pc[0]),
        .alu_rd    (rd[0]), .alu_wb (w[0]), .alu_data (dat[0]), .alu_ready (rdy[0]),
        .lsu_valid (v[1]), .lsu_wid (wid[1]), .lsu_tmask (tm[1]), .lsu_PC (pc[1]),
        .lsu_rd    (rd[1]), .lsu_wb (w[1]), .lsu_data (dat[1]), .lsu_ready (rdy[1]),
        .csr_valid (v[2]), .csr_wid (wid[2]), .csr_tmask (tm[2]), .csr_PC (pc[2]),
        .csr_rd    (rd[2]), .csr_wb (w[2]), .csr_data (dat[2]), .csr_ready (rdy[2]),
        .fpu_valid (v[3]), .fpu_wid (wid[3]), .fpu_tmask (tm[3]), .fpu_PC (pc[3]),
        .fpu_rd    (rd[3]), .fpu_wb (w[3]), .fpu_data (dat[3]), .fpu_ready (rdy[3]),
        .gpu_valid (v[4]), .gpu_wid (wid[4]), .gpu_tmask (tm[4]), .gpu_PC (pc[4]),
        .gpu_rd    (rd[4]), .gpu_wb (w[4]), .gpu_data (dat[4]), .gpu_ready (rdy[4]),
        .wb_valid  (wb_valid),
        .wb_wid    (wb_wid),
        .wb_tmask  (wb_tmask),
        .wb_PC     (wb_PC),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int cyc;
        int unit;
    } obs_t;

    obs_t          obs[$];
    int            cyc    = 0;
    int            last_u = 4;
    bit            ev     = 1'b0;
    logic [NW-1:0] e_wid;
    logic [NT-1:0] e_tm;
    logic [31:0]   e_pc;
    logic [NR-1:0] e_rd;
    logic [DW-1:0] e_dat;

    function automatic bit present(input int u);
        return (u != 3) || HAS_FPU;
    endfunction

    function automatic int pick();
        for (int k = 1; k <= 5; k++) begin
            int u;
            u = (last_u + k) % 5;
            if (present(u) && v[u] && w[u])
                return u;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int g;
        cyc++;
        if (reset) begin
            ev     = 1'b0;
            last_u = 4;
        end else if (!ev || wb_ready) begin
            g = pick();
            if (g >= 0) begin
                ev     = 1'b1;
                e_wid  = wid[g];
                e_tm   = tm[g];
                e_pc   = pc[g];
                e_rd   = rd[g];
                e_dat  = dat[g];
                last_u = g;
            end else begin
                ev = 1'b0;
            end
        end
    endtask

    task automatic compare();
        int g;
        bit free;
        bit er;
        free = !ev || wb_ready;
        g    = pick();
        chk("wb_valid", 128'(wb_valid), 128'(ev));
        if (ev) begin
            chk("wb_wid",   128'(wb_wid),   128'(e_wid));
            chk("wb_tmask", 128'(wb_tmask), 128'(e_tm));
            chk("wb_PC",    128'(wb_PC),    128'(e_pc));
            chk("wb_rd",    128'(wb_rd),    128'(e_rd));
            chk("wb_data",  128'(wb_data),  128'(e_dat));
        end
        for (int u = 0; u < 5; u++) begin
            er = !reset && present(u) && (!w[u] || (free && g == u));
            chk($sformatf("ready[%0d]", u), 128'(rdy[u]), 128'(er));
        end
        if (wb_valid === 1'b1 && wb_ready)
            obs.push_back('{cyc: cyc, unit: int'(wb_PC[15:12]) - 1});
    endtask

    initial begin
        @(posedge clk);
        model_edge();
        forever begin
            @(negedge clk);
            #2;
            compare();
            @(posedge clk);
            model_edge();
        end
    end

    // ---------------- stimulus ----------------
    task automatic load(input int u, input int n, input bit wbv,
                        input logic [NR-1:0] rdv, input logic [31:0] lane0);
        if (present(u)) begin
            cnt[u] = n;
            v[u]   = (n > 0);
            w[u]   = wbv;
            wid[u] = NW'(u);
            tm[u]  = NT'(u + 1);
            pc[u]  = 32'h1000 * 32'(u + 1);
            rd[u]  = rdv;
            dat[u] = {32'hA000_0000 + 32'(u), 32'h5555_0000, 32'h1234_5678, lane0};
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #3;
        for (int u = 0; u < 5; u++)
            acc[u] = v[u] && rdy[u];
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int u = 0; u < 5; u++) begin
            if (acc[u]) begin
                cnt[u] = cnt[u] - 1;
                pc[u]  = pc[u] + 32'd4;
                rd[u]  = rd[u] + NR'(1);
                dat[u] = dat[u] + DW'(1);
                if (cnt[u] == 0)
                    v[u] = 1'b0;
            end
        end
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    function automatic bit busy();
        for (int u = 0; u < 5; u++)
            if (cnt[u] > 0)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((busy() || ev) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_in_budget", 128'(n < maxc), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

    initial begin
        int c0;
        for (int u = 0; u < 5; u++) begin
            wid[u] = '0;
            tm[u]  = '0;
            pc[u]  = '0;
            rd[u]  = '0;
            dat[u] = '0;
            cnt[u] = 0;
        end

        // Reset, then ALU and GPU pending at release: ALU at +1, GPU at +2.
        load(0, 1, 1'b1, 5'd1, 32'h1111_1111);
        load(4, 1, 1'b1, 5'd2, 32'h4444_4444);
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("rst_wb_valid",  128'(wb_valid), 128'(0));
            chk("rst_alu_ready", 128'(rdy[0]),   128'(0));
            chk("rst_gpu_ready", 128'(rdy[4]),   128'(0));
            advance();
        end
        reset = 1'b0;
        c0    = cyc;
        obs.delete();
        run_idle(20);
        chk("rel_count",     128'(obs.size()), 128'(2));
        chk("rel_first_u",   128'(obs.size() > 0 ? obs[0].unit : -1), 128'(0));
        chk("rel_first_cyc", 128'(obs.size() > 0 ? obs[0].cyc  : -1), 128'(c0 + 1));
        chk("rel_second_u",  128'(obs.size() > 1 ? obs[1].unit : -1), 128'(4));
        chk("rel_second_cyc",128'(obs.size() > 1 ? obs[1].cyc  : -1), 128'(c0 + 2));

        // All units competing: strict rotation, one writeback per cycle.
        obs.delete();
        for (int u = 0; u < 5; u++)
            load(u, 3, 1'b1, NR'(u * 6), 32'hC0DE_0000 + 32'(u));
        run_idle(60);
        chk("rr_count", 128'(obs.size()), 128'(NREQ * 3));
        for (int k = 0; k < obs.size(); k++) begin
            chk($sformatf("rr_unit[%0d]", k), 128'(obs[k].unit), 128'(order[k % NREQ]));
            chk($sformatf("rr_cyc[%0d]",  k), 128'(obs[k].cyc),  128'(obs[0].cyc + k));
        end

        // Back-pressure: LSU rd=7 / 0xDEADBEEF held for 3 cycles.
        obs.delete();
        wb_ready = 1'b0;
        load(1, 2, 1'b1, 5'd7, 32'hDEAD_BEEF);
        step();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("hold_valid",     128'(wb_valid),       128'(1));
            chk("hold_rd",        128'(wb_rd),          128'(7));
            chk("hold_lane0",     128'(wb_data[31:0]),  128'(32'hDEAD_BEEF));
            chk("hold_lsu_ready", 128'(rdy[1]),         128'(0));
            advance();
        end
        wb_ready = 1'b1;
        run_idle(20);
        chk("hold_count", 128'(obs.size()), 128'(2));

        // CSR drop (wb=0) and ALU grant complete in the same cycle.
        obs.delete();
        load(2, 1, 1'b0, 5'd3, 32'h0303_0303);
        load(0, 1, 1'b1, 5'd9, 32'h0A0A_0A0A);
        sample();
        chk("drop_csr_ready", 128'(rdy[2]), 128'(1));
        chk("drop_alu_ready", 128'(rdy[0]), 128'(1));
        advance();
        sample();
        chk("drop_wb_valid", 128'(wb_valid), 128'(1));
        chk("drop_wb_PC",    128'(wb_PC),    128'(32'h1000));
        chk("drop_wb_rd",    128'(wb_rd),    128'(9));
        advance();
        run_idle(20);
        chk("drop_count", 128'(obs.size()), 128'(1));

        // Reset while a writeback is stalled; the pointer was left at LSU.
        wb_ready = 1'b0;
        load(1, 1, 1'b1, 5'd12, 32'h1212_1212);
        step();
        load(0, 1, 1'b1, 5'd13, 32'h1313_1313);
        load(2, 1, 1'b1, 5'd14, 32'h1414_1414);
        step();
        reset = 1'b1;
        sample();
        chk("mid_rst_alu_ready", 128'(rdy[0]), 128'(0));
        chk("mid_rst_csr_ready", 128'(rdy[2]), 128'(0));
        advance();
        reset    = 1'b0;
        wb_ready = 1'b1;
        sample();
        chk("mid_rst_wb_valid", 128'(wb_valid), 128'(0));
        advance();
        sample();
        chk("post_rst_valid", 128'(wb_valid), 128'(1));
        chk("post_rst_first", 128'(wb_PC),    128'(32'h1000));
        advance();
        run_idle(20);
        chk("fpu_ready_idle", 128'(rdy[3]), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
